// File: rtl/fft_output_reorder_pkg.sv
// fft_pkg: shared sizes, read-FSM encoding and the bit-reverse helper for
// the FFT output reorder buffer.
package fft_pkg;

    localparam int unsigned WORDSIZE   = 16;
    localparam int unsigned ADDRSIZE   = 8;
    localparam int unsigned NUMSAMPLES = 256;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        PRIME  = 2'b01,
        STREAM = 2'b10
    } rd_state_e;

    // Reverse all ADDRSIZE bits of a sample index.
    function automatic logic [ADDRSIZE-1:0] bitrev(input logic [ADDRSIZE-1:0] i);
        logic [ADDRSIZE-1:0] r;
        for (int unsigned b = 0; b < ADDRSIZE; b++) begin
            r[b] = i[ADDRSIZE-1-b];
        end
        return r;
    endfunction

endpackage

// File: rtl/fft_output_reorder_if.sv
// fft_output_reorder_if: 4-lane input beat from the last FFT stage plus the
// serial valid/ready output stream and status flags.
//   slave  : reorder block side (consumes beats, produces stream)
//   master : producer/unloader side (drives beats and out_ready)
interface fft_output_reorder_if #(
    parameter int unsigned WORDSIZE = fft_pkg::WORDSIZE,
    parameter int unsigned ADDRSIZE = fft_pkg::ADDRSIZE
);
    logic                in_valid;
    logic [WORDSIZE-1:0] in_data0;
    logic [WORDSIZE-1:0] in_data1;
    logic [WORDSIZE-1:0] in_data2;
    logic [WORDSIZE-1:0] in_data3;
    logic                out_valid;
    logic                out_ready;
    logic [WORDSIZE-1:0] out_data;
    logic [ADDRSIZE-1:0] out_index;
    logic                frame_done;
    logic                overflow;

    modport master (
        output in_valid, in_data0, in_data1, in_data2, in_data3, out_ready,
        input  out_valid, out_data, out_index, frame_done, overflow
    );

    modport slave (
        input  in_valid, in_data0, in_data1, in_data2, in_data3, out_ready,
        output out_valid, out_data, out_index, frame_done, overflow
    );
endinterface

// File: rtl/fft_reorder_bank.sv
// fft_reorder_bank: one frame of sample storage.
//   clk   : clock
//   we    : write all four lanes this cycle
//   waddr : beat address; lane k lands at {waddr, k}
//   wdata : four lane words, element k is lane k
//   raddr : read address
//   rdata : word at raddr, registered (1-cycle latency)
module fft_reorder_bank #(
    parameter int unsigned WORDSIZE = 16,
    parameter int unsigned ADDRSIZE = 8
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [ADDRSIZE-3:0]      waddr,
    input  logic [3:0][WORDSIZE-1:0] wdata,
    input  logic [ADDRSIZE-1:0]      raddr,
    output logic [WORDSIZE-1:0]      rdata
);
    localparam int unsigned DEPTH = 1 << ADDRSIZE;

    logic [WORDSIZE-1:0] mem [DEPTH];

    // Plain RAM: no reset on storage or read register.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int unsigned k = 0; k < 4; k++) begin
                mem[{waddr, 2'(k)}] <= wdata[k];
            end
        end
        rdata <= mem[raddr];
    end
endmodule

// File: rtl/fft_output_reorder.sv
// fft_output_reorder: captures 4-lane FFT result beats into a ping-pong
// buffer and streams each completed frame out serially in bit-reversed
// address order (natural sample order) over valid/ready.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus.in_*   : beat strobe and four lane words
//   bus.out_*  : serial stream (out_valid/out_ready/out_data/out_index)
//   bus.frame_done : pulse after the handshake of the last index
//   bus.overflow   : sticky, a beat arrived while both banks were full
module fft_output_reorder #(
    parameter int unsigned WORDSIZE   = fft_pkg::WORDSIZE,
    parameter int unsigned ADDRSIZE   = fft_pkg::ADDRSIZE,
    parameter int unsigned NUMSAMPLES = fft_pkg::NUMSAMPLES
) (
    input logic clk,
    input logic rst_n,
    fft_output_reorder_if.slave bus
);
    import fft_pkg::*;

    localparam int unsigned BEATBITS = ADDRSIZE - 2;

    // write side
    logic                     wbank, wbank_nxt_c;
    logic [BEATBITS-1:0]      wcnt;
    logic [1:0]               full, full_set_c, full_clr_c, full_nxt_c;
    logic                     wr_accept_c, wr_last_c, overflow_q;
    logic [3:0][WORDSIZE-1:0] wdata_c;

    // read side
    rd_state_e           state, state_nxt;
    logic                rd_bank, rd_bank_nxt;
    logic [ADDRSIZE-1:0] rcnt, rcnt_nxt, raddr_c;
    logic [WORDSIZE-1:0] rdata0, rdata1, rdata_c;
    logic                out_valid_q, out_valid_nxt;
    logic [WORDSIZE-1:0] out_data_q, out_data_nxt;
    logic [ADDRSIZE-1:0] out_index_q, out_index_nxt;
    logic                frame_done_q, frame_done_nxt;
    logic                handshake_c, other_full_c;

    assign wdata_c     = {bus.in_data3, bus.in_data2, bus.in_data1, bus.in_data0};
    assign wr_accept_c = bus.in_valid && !full[wbank];
    assign wr_last_c   = wr_accept_c && (wcnt == '1);
    assign full_set_c  = wr_last_c ? (2'b01 << wbank) : 2'b00;

    fft_reorder_bank #(.WORDSIZE(WORDSIZE), .ADDRSIZE(ADDRSIZE)) u_bank0 (
        .clk(clk), .we(wr_accept_c && !wbank), .waddr(wcnt), .wdata(wdata_c),
        .raddr(raddr_c), .rdata(rdata0)
    );

    fft_reorder_bank #(.WORDSIZE(WORDSIZE), .ADDRSIZE(ADDRSIZE)) u_bank1 (
        .clk(clk), .we(wr_accept_c && wbank), .waddr(wcnt), .wdata(wdata_c),
        .raddr(raddr_c), .rdata(rdata1)
    );

    // Clearing wins over filling; the writer moves to whichever bank is free.
    always_comb begin
        full_nxt_c  = (full | full_set_c) & ~full_clr_c;
        wbank_nxt_c = wbank;
        if (full_nxt_c[wbank] && !full_nxt_c[~wbank]) begin
            wbank_nxt_c = ~wbank;
        end
    end

    // Write-side state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wbank      <= 1'b0;
            wcnt       <= '0;
            full       <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (wr_accept_c) begin
                wcnt <= wcnt + 1'b1;
            end
            if (bus.in_valid && full[wbank]) begin
                overflow_q <= 1'b1;
            end
            full  <= full_nxt_c;
            wbank <= wbank_nxt_c;
        end
    end

    // The bank read register doubles as the prefetch slot: it always holds
    // the word after the one on out_data, so a handshake reloads out_data
    // from it while the RAM fetches the next one.
    assign rdata_c      = rd_bank ? rdata1 : rdata0;
    assign handshake_c  = out_valid_q && bus.out_ready;
    assign other_full_c = full[~rd_bank] | full_set_c[~rd_bank];

    // Read FSM next state and outputs.
    always_comb begin
        state_nxt      = state;
        rd_bank_nxt    = rd_bank;
        rcnt_nxt       = rcnt;
        out_valid_nxt  = out_valid_q;
        out_data_nxt   = out_data_q;
        out_index_nxt  = out_index_q;
        frame_done_nxt = 1'b0;
        full_clr_c     = 2'b00;
        raddr_c        = bitrev(rcnt + 1'b1);
        case (state)
            IDLE: begin
                if (full[~wbank]) begin
                    rd_bank_nxt = ~wbank;
                    rcnt_nxt    = '0;
                    raddr_c     = '0;
                    state_nxt   = PRIME;
                end
            end
            PRIME: begin
                out_valid_nxt = 1'b1;
                out_data_nxt  = rdata_c;
                out_index_nxt = rcnt;
                state_nxt     = STREAM;
            end
            STREAM: begin
                if (handshake_c) begin
                    if (rcnt == ADDRSIZE'(NUMSAMPLES - 1)) begin
                        frame_done_nxt      = 1'b1;
                        full_clr_c[rd_bank] = 1'b1;
                        out_valid_nxt       = 1'b0;
                        if (other_full_c) begin
                            rd_bank_nxt = ~rd_bank;
                            rcnt_nxt    = '0;
                            raddr_c     = '0;
                            state_nxt   = PRIME;
                        end else begin
                            state_nxt = IDLE;
                        end
                    end else begin
                        rcnt_nxt      = rcnt + 1'b1;
                        out_data_nxt  = rdata_c;
                        out_index_nxt = rcnt + 1'b1;
                        raddr_c       = bitrev(rcnt + ADDRSIZE'(2));
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Read FSM state and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            rd_bank      <= 1'b0;
            rcnt         <= '0;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_index_q  <= '0;
            frame_done_q <= 1'b0;
        end else begin
            state        <= state_nxt;
            rd_bank      <= rd_bank_nxt;
            rcnt         <= rcnt_nxt;
            out_valid_q  <= out_valid_nxt;
            out_data_q   <= out_data_nxt;
            out_index_q  <= out_index_nxt;
            frame_done_q <= frame_done_nxt;
        end
    end

    assign bus.out_valid  = out_valid_q;
    assign bus.out_data   = out_data_q;
    assign bus.out_index  = out_index_q;
    assign bus.frame_done = frame_done_q;
    assign bus.overflow   = overflow_q;
endmodule

// File: tb/tb_fft_output_reorder.sv
// Directed bench for fft_output_reorder: linear fill, backpressure,
// back-to-back frames, overflow, reset mid-stream and simultaneous swap.
module tb_fft_output_reorder;
    localparam int unsigned W = 16;
    localparam int unsigned A = 8;
    localparam int unsigned N = 256;

    typedef struct {
        int idx;
        int exp;
    } vec_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    fft_output_reorder_if #(.WORDSIZE(W), .ADDRSIZE(A)) bus ();

    fft_output_reorder #(.WORDSIZE(W), .ADDRSIZE(A), .NUMSAMPLES(N)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );

    int n_vec = 0;
    int n_bad = 0;
    int pcyc  = 0;
    int last_edge = 0;
    int hs_idx[$];
    int hs_dat[$];
    int hs_edge[$];
    int fv_edge[$];
    int fd_edge[$];
    logic stall_prev = 1'b0;
    logic valid_prev = 1'b0;
    logic [W-1:0] d_prev = '0;
    logic [A-1:0] i_prev = '0;

    always @(posedge clk) pcyc <= pcyc + 1;

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic int brev(input int i);
        int r = 0;
        for (int b = 0; b < 8; b++) begin
            if (i[b]) r = r | (1 << (7 - b));
        end
        return r;
    endfunction

    // Output monitor: records handshakes, frame_done pulses and checks that
    // a stalled word stays put.
    always @(negedge clk) begin
        if (!rst_n) begin
            stall_prev <= 1'b0;
            valid_prev <= 1'b0;
        end else begin
            if (stall_prev) begin
                check("stall_valid", int'(bus.out_valid), 1);
                check("stall_data", int'(bus.out_data), int'(d_prev));
                check("stall_index", int'(bus.out_index), int'(i_prev));
            end
            if (bus.out_valid && !valid_prev) fv_edge.push_back(pcyc);
            if (bus.out_valid && bus.out_ready) begin
                hs_idx.push_back(int'(bus.out_index));
                hs_dat.push_back(int'(bus.out_data));
                hs_edge.push_back(pcyc + 1);
            end
            if (bus.frame_done) fd_edge.push_back(pcyc);
            stall_prev <= bus.out_valid && !bus.out_ready;
            valid_prev <= bus.out_valid;
            d_prev     <= bus.out_data;
            i_prev     <= bus.out_index;
        end
    end

    task automatic clear_log();
        hs_idx.delete();
        hs_dat.delete();
        hs_edge.delete();
        fv_edge.delete();
        fd_edge.delete();
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        clear_log();
    endtask

    // Beats first..last with lane k = base + 4*b + k, one beat every gap cycles.
    task automatic send_beats(input int base, input int first, input int last, input int gap);
        for (int b = first; b <= last; b++) begin
            tick();
            bus.in_valid = 1'b1;
            bus.in_data0 = W'(base + 4 * b + 0);
            bus.in_data1 = W'(base + 4 * b + 1);
            bus.in_data2 = W'(base + 4 * b + 2);
            bus.in_data3 = W'(base + 4 * b + 3);
            last_edge = pcyc + 1;
            for (int g = 1; g < gap; g++) begin
                tick();
                bus.in_valid = 1'b0;
            end
        end
        tick();
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_hs(input string name, input int n, input int budget);
        int c = 0;
        while (hs_dat.size() < n && c < budget) begin
            @(posedge clk);
            c++;
        end
        #1;
        check(name, hs_dat.size(), n);
    endtask

    // One frame in natural order starting at log position start.
    task automatic check_stream(input string name, input int start, input int base);
        int errs = 0;
        for (int j = 0; j < int'(N); j++) begin
            if (start + j >= hs_dat.size()) errs++;
            else if (hs_idx[start + j] != j || hs_dat[start + j] != base + brev(j)) errs++;
        end
        check(name, errs, 0);
    endtask

    initial begin
        vec_t lin_tab[11];
        vec_t b2b_tab[5];
        int swap_edge;
        int c;

        lin_tab[0]  = '{0, 0};     lin_tab[1]  = '{1, 128};  lin_tab[2]  = '{2, 64};
        lin_tab[3]  = '{3, 192};   lin_tab[4]  = '{4, 32};   lin_tab[5]  = '{16, 8};
        lin_tab[6]  = '{100, 38};  lin_tab[7]  = '{128, 1};  lin_tab[8]  = '{200, 19};
        lin_tab[9]  = '{254, 127}; lin_tab[10] = '{255, 255};
        b2b_tab[0]  = '{256, 256}; b2b_tab[1]  = '{257, 384}; b2b_tab[2] = '{259, 448};
        b2b_tab[3]  = '{356, 294}; b2b_tab[4]  = '{511, 511};

        bus.in_valid  = 1'b0;
        bus.in_data0  = '0;
        bus.in_data1  = '0;
        bus.in_data2  = '0;
        bus.in_data3  = '0;
        bus.out_ready = 1'b0;

        // reset values
        @(negedge clk);
        check("rst_out_valid", int'(bus.out_valid), 0);
        check("rst_out_data", int'(bus.out_data), 0);
        check("rst_out_index", int'(bus.out_index), 0);
        check("rst_frame_done", int'(bus.frame_done), 0);
        check("rst_overflow", int'(bus.overflow), 0);
        do_reset();

        // linear fill
        bus.out_ready = 1'b1;
        send_beats(0, 0, 63, 1);
        wait_hs("lin_count", 256, 600);
        check("lin_latency", (fv_edge.size() > 0) ? fv_edge[0] - last_edge : -1, 2);
        for (int v = 0; v < 11; v++) begin
            check($sformatf("lin_idx%0d", lin_tab[v].idx),
                  (hs_dat.size() > lin_tab[v].idx) ? hs_dat[lin_tab[v].idx] : -1, lin_tab[v].exp);
        end
        check_stream("lin_stream", 0, 0);
        repeat (3) tick();
        check("lin_frame_done_cnt", fd_edge.size(), 1);
        check("lin_frame_done_time", (fd_edge.size() > 0 && hs_edge.size() > 255) ? fd_edge[0] - hs_edge[255] : -1, 0);
        check("lin_idle_valid", int'(bus.out_valid), 0);

        // random backpressure
        do_reset();
        fork
            send_beats(4096, 0, 63, 4);
            for (int k = 0; k < 4000 && hs_dat.size() < 256; k++) begin
                tick();
                bus.out_ready = 1'($urandom_range(0, 1));
            end
        join
        bus.out_ready = 1'b1;
        wait_hs("bp_count", 256, 100);
        check_stream("bp_stream", 0, 4096);
        repeat (3) tick();
        check("bp_frame_done_cnt", fd_edge.size(), 1);

        // back-to-back frames
        do_reset();
        bus.out_ready = 1'b1;
        send_beats(0, 0, 127, 1);
        wait_hs("b2b_count", 512, 1500);
        check_stream("b2b_frame0", 0, 0);
        check_stream("b2b_frame1", 256, 256);
        for (int v = 0; v < 5; v++) begin
            check($sformatf("b2b_pos%0d", b2b_tab[v].idx),
                  (hs_dat.size() > b2b_tab[v].idx) ? hs_dat[b2b_tab[v].idx] : -1, b2b_tab[v].exp);
        end
        repeat (3) tick();
        check("b2b_frame_done_cnt", fd_edge.size(), 2);
        check("b2b_overflow", int'(bus.overflow), 0);

        // overflow: third frame dropped while stalled
        do_reset();
        send_beats(0, 0, 127, 1);
        check("ovf_before", int'(bus.overflow), 0);
        send_beats(512, 0, 0, 1);
        check("ovf_first_drop", int'(bus.overflow), 1);
        send_beats(512, 1, 63, 1);
        bus.out_ready = 1'b1;
        wait_hs("ovf_count", 512, 1500);
        check_stream("ovf_frame1", 0, 0);
        check_stream("ovf_frame2", 256, 256);
        repeat (20) tick();
        check("ovf_no_extra", hs_dat.size(), 512);
        check("ovf_sticky", int'(bus.overflow), 1);
        check("ovf_frame_done_cnt", fd_edge.size(), 2);

        // simultaneous swap: bank 1 fills on bank 0's last handshake
        do_reset();
        send_beats(0, 0, 63, 1);
        send_beats(8192, 0, 62, 1);
        bus.out_ready = 1'b1;
        swap_edge = -1;
        c = 0;
        while (c < 1000) begin
            @(negedge clk);
            c++;
            if (bus.out_valid && bus.out_index == A'(255)) break;
        end
        check("swap_reached_last", c < 1000 ? 1 : 0, 1);
        swap_edge = pcyc + 1;
        #1;
        bus.in_valid = 1'b1;
        bus.in_data0 = W'(8192 + 252);
        bus.in_data1 = W'(8192 + 253);
        bus.in_data2 = W'(8192 + 254);
        bus.in_data3 = W'(8192 + 255);
        tick();
        bus.in_valid = 1'b0;
        send_beats(12288, 0, 63, 1);
        wait_hs("swap_count", 768, 2000);
        check("swap_coincide", (hs_edge.size() > 255) ? hs_edge[255] : -1, swap_edge);
        check("swap_bubble", (hs_edge.size() > 256) ? int'(hs_edge[256] - hs_edge[255] <= 2) : 0, 1);
        check_stream("swap_frameA", 0, 0);
        check_stream("swap_frameB", 256, 8192);
        check_stream("swap_frameC", 512, 12288);
        repeat (3) tick();
        check("swap_frame_done_cnt", fd_edge.size(), 3);
        check("swap_overflow", int'(bus.overflow), 0);

        // reset in the middle of a frame
        do_reset();
        bus.out_ready = 1'b1;
        send_beats(16384, 0, 63, 1);
        c = 0;
        while (c < 1000) begin
            @(negedge clk);
            c++;
            if (bus.out_valid && bus.out_index == A'(100)) break;
        end
        check("mid_reached_100", c < 1000 ? 1 : 0, 1);
        rst_n = 1'b0;
        #1;
        check("mid_out_valid", int'(bus.out_valid), 0);
        check("mid_frame_done", int'(bus.frame_done), 0);
        check("mid_out_index", int'(bus.out_index), 0);
        check("mid_out_data", int'(bus.out_data), 0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        clear_log();
        repeat (300) tick();
        check("mid_no_partial", hs_dat.size(), 0);
        send_beats(20480, 0, 63, 1);
        wait_hs("mid_new_count", 256, 600);
        check_stream("mid_new_frame", 0, 20480);
        repeat (3) tick();
        check("mid_frame_done_cnt", fd_edge.size(), 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
